// File: rtl/oped_axis_pkg.sv
// rtl/oped_axis_pkg.sv - shared widths, status bit positions and beat type for the OPED ingress path
package oped_axis_pkg;

    localparam int DAT_W  = 256;
    localparam int STRB_W = 32;
    localparam int LEN_W  = 16;
    localparam int PORT_W = 8;
    localparam int ACC_W  = 17;
    localparam int USER_W = 32;
    localparam int STAT_W = 3;

    localparam int STAT_MISSING_HDR  = 0;
    localparam int STAT_LEN_MISMATCH = 1;
    localparam int STAT_UPSTREAM_ERR = 2;

    typedef struct packed {
        logic [DAT_W-1:0]  data;
        logic [STRB_W-1:0] strb;
        logic              last;
        logic [USER_W-1:0] user;
        logic [STAT_W-1:0] stat;
    } beat_t;

    function automatic logic [5:0] popcount_strb(input logic [STRB_W-1:0] v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < STRB_W; i++) begin
            c = c + {5'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/oped_axis_skid.sv
// rtl/oped_axis_skid.sv - 2-entry register slice (main + skid) over beat_t
module oped_axis_skid
    import oped_axis_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_ni,
    input  beat_t s_beat_i,
    input  logic  s_valid_i,
    output logic  s_ready_o,
    output beat_t m_beat_o,
    output logic  m_valid_o,
    input  logic  m_ready_i
);

    beat_t main_q, main_d, skid_q, skid_d;
    logic  main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
    logic  rdy_en_q;
    logic  push, pop;

    // Skid entry only fills while main is held, so a full buffer is exactly skid_vld_q.
    assign s_ready_o = rdy_en_q & ~skid_vld_q;
    assign push      = s_valid_i & s_ready_o;
    assign pop       = main_vld_q & m_ready_i;
    assign m_beat_o  = main_q;
    assign m_valid_o = main_vld_q;

    always_comb begin
        main_d     = main_q;
        main_vld_d = main_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (!main_vld_q || pop) begin
            if (skid_vld_q) begin
                main_d     = skid_q;
                main_vld_d = 1'b1;
                skid_vld_d = 1'b0;
            end else begin
                if (push) main_d = s_beat_i;
                main_vld_d = push;
            end
        end else if (push) begin
            skid_d     = s_beat_i;
            skid_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            main_q     <= '0;
            main_vld_q <= 1'b0;
            skid_q     <= '0;
            skid_vld_q <= 1'b0;
            rdy_en_q   <= 1'b0;
        end else begin
            main_q     <= main_d;
            main_vld_q <= main_vld_d;
            skid_q     <= skid_d;
            skid_vld_q <= skid_vld_d;
            rdy_en_q   <= 1'b1;
        end
    end

endmodule

// File: rtl/oped_ingress_checker.sv
// rtl/oped_ingress_checker.sv - OPED ingress sideband packing, length check and packet/error counters
module oped_ingress_checker
    import oped_axis_pkg::*;
#(
    parameter int DW = 256,
    parameter int LW = 16,
    parameter int PW = 8,
    parameter int CW = 32
) (
    input  logic            ACLK,
    input  logic            ARESETN,
    input  logic [DW-1:0]   s_dat_tdata,
    input  logic [DW/8-1:0] s_dat_tstrb,
    input  logic            s_dat_tlast,
    input  logic            s_dat_tvalid,
    output logic            s_dat_tready,
    input  logic [LW-1:0]   s_len_tdata,
    input  logic            s_len_tvalid,
    input  logic [PW-1:0]   s_spt_tdata,
    input  logic [PW-1:0]   s_dpt_tdata,
    input  logic            s_err_tvalid,
    output logic [DW-1:0]   m_tdata,
    output logic [DW/8-1:0] m_tstrb,
    output logic            m_tlast,
    output logic            m_tvalid,
    input  logic            m_tready,
    output logic [31:0]     m_tuser,
    output logic [2:0]      m_tstat,
    input  logic            clr_counts,
    output logic [CW-1:0]   pkt_count,
    output logic [CW-1:0]   err_count
);

    logic             sof_q, sof_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [LW-1:0]    len_q, len_d;
    logic             miss_q, miss_d;
    logic             err_q, err_d;
    logic [CW-1:0]    pkt_q, pkt_d, errc_q, errc_d;

    logic             accept;
    logic [LW-1:0]    len_eff;
    logic             miss_eff, err_eff;
    logic [ACC_W:0]   acc_sum;
    logic [ACC_W-1:0] acc_next;
    beat_t            beat_in, beat_out;
    logic             pop_last;

    assign accept = s_dat_tvalid & s_dat_tready;

    always_comb begin
        len_eff  = sof_q ? (s_len_tvalid ? s_len_tdata : '0) : len_q;
        miss_eff = sof_q ? ~s_len_tvalid : miss_q;
        err_eff  = err_q | s_err_tvalid;
        // acc_q is already zero on a first beat, so no start-of-packet mux is needed here.
        acc_sum  = {1'b0, acc_q} + {12'd0, popcount_strb(s_dat_tstrb)};
        acc_next = acc_sum[ACC_W] ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];

        beat_in      = '0;
        beat_in.data = s_dat_tdata;
        beat_in.strb = s_dat_tstrb;
        beat_in.last = s_dat_tlast;
        beat_in.user = sof_q ? {s_dpt_tdata, s_spt_tdata, s_len_tdata} : '0;
        if (s_dat_tlast) begin
            beat_in.stat[STAT_UPSTREAM_ERR] = err_eff;
            beat_in.stat[STAT_LEN_MISMATCH] = (acc_next != {1'b0, len_eff});
            beat_in.stat[STAT_MISSING_HDR]  = miss_eff;
        end

        sof_d  = sof_q;
        acc_d  = acc_q;
        len_d  = len_q;
        miss_d = miss_q;
        err_d  = err_q;
        if (accept) begin
            if (s_dat_tlast) begin
                sof_d  = 1'b1;
                acc_d  = '0;
                len_d  = '0;
                miss_d = 1'b0;
                err_d  = 1'b0;
            end else begin
                sof_d  = 1'b0;
                acc_d  = acc_next;
                len_d  = len_eff;
                miss_d = miss_eff;
                err_d  = err_eff;
            end
        end
    end

    oped_axis_skid u_skid (
        .clk_i     (ACLK),
        .rst_ni    (ARESETN),
        .s_beat_i  (beat_in),
        .s_valid_i (s_dat_tvalid),
        .s_ready_o (s_dat_tready),
        .m_beat_o  (beat_out),
        .m_valid_o (m_tvalid),
        .m_ready_i (m_tready)
    );

    assign m_tdata  = beat_out.data;
    assign m_tstrb  = beat_out.strb;
    assign m_tlast  = beat_out.last;
    assign m_tuser  = beat_out.user;
    assign m_tstat  = beat_out.stat;
    assign pop_last = m_tvalid & m_tready & m_tlast;

    always_comb begin
        pkt_d  = pkt_q + {{(CW-1){1'b0}}, pop_last};
        errc_d = errc_q + {{(CW-1){1'b0}}, pop_last & (|m_tstat)};
        if (clr_counts) begin
            pkt_d  = '0;
            errc_d = '0;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            sof_q  <= 1'b1;
            acc_q  <= '0;
            len_q  <= '0;
            miss_q <= 1'b0;
            err_q  <= 1'b0;
            pkt_q  <= '0;
            errc_q <= '0;
        end else begin
            sof_q  <= sof_d;
            acc_q  <= acc_d;
            len_q  <= len_d;
            miss_q <= miss_d;
            err_q  <= err_d;
            pkt_q  <= pkt_d;
            errc_q <= errc_d;
        end
    end

    assign pkt_count = pkt_q;
    assign err_count = errc_q;

endmodule
